yreg_file: RTL and testbench
============================

Name: yreg_file

Overview:
- Two-read, one-write register file for the single-cycle datapath.
- Sits directly upstream of the 2:1 operand muxes. Read port 2 feeds the ALU-source mux, which selects register vs. immediate. Read port 1 drives the ALU A input.
- Write port is fed by the write-back mux, which selects ALU result vs. memory data.
- Register 0 is hardwired to zero, as in MIPS/RISC-V.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR, 5, address width; register count is 2**ADDR.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- rn1  input  ADDR  read address, port 1.
- rn2  input  ADDR  read address, port 2.
- wn   input  ADDR  write address.
- d    input  WIDTH  write data.
- w    input  1  write enable, sampled on the rising clk edge.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: 2**ADDR registers of WIDTH bits, all flip-flop based.
- Reset:
  - rst high clears every register to 0 immediately, with no clock needed.
  - While rst is high, rd1 = rd2 = 0 and writes are ignored.
  - Reset asserted mid-cycle or coincident with a clk edge always wins; no write occurs on that edge.
- Write:
  - On a rising clk edge with rst low, w = 1 and wn != 0, register[wn] <= d.
  - Takes effect one edge later (new value stored at the edge).
  - w = 0: no register changes.
  - wn = 0: write silently discarded; register 0 is never non-zero.
- Read:
  - Combinational, zero latency.
  - rdN = 0 when rnN == 0.
  - Otherwise rdN = register[rnN].
- Write-through bypass, same cycle:
  - If rst low, w = 1, wn != 0 and wn == rnN, then rdN = d (the incoming value) before the edge.
  - This lets a downstream mux see the value being written this cycle.
  - The bypass never applies when wn == 0.
- Both ports are independent:
  - rn1 == rn2 returns identical data on both.
  - Both may bypass simultaneously.
- Address width rule: all ADDR bits are decoded; there are no aliased or unused registers.
- Outputs carry no X after reset. Unwritten registers read 0.
- No internal state beyond the register array, so no FSM. Sequential behaviour is limited to the write, reset and bypass timing above.
- Implementation: a generate loop of per-register WIDTH-bit D flip-flops with enable (async clear), plus two read muxes built from 2:1 mux trees.

Test Plan:
1. Reset: assert rst, then read every address on both ports -> all reads = 0. Deassert rst.
2. Write then read: w=1, wn=5, d=32'hDEADBEEF, one clk edge; then w=0, rn1=5, rn2=5 -> rd1 = rd2 = 32'hDEADBEEF.
3. Register 0: w=1, wn=0, d=32'hFFFFFFFF, edge -> rn1=0 gives 0. Also check no bypass: during that cycle rd1 = 0 with rn1 = 0.
4. Bypass: reg 7 = 32'h11 already; w=1, wn=7, d=32'h22, rn1=7, rn2=3, before the edge -> rd1 = 32'h22 and rd2 = reg 3. After the edge with w=0 -> rd1 = 32'h22.
5. Write disabled: w=0, wn=9, d=32'hABCD, edge -> reg 9 unchanged (0 after reset).
6. Reset mid-operation: regs 1..4 loaded with 1..4; assert rst asynchronously between edges -> rd1/rd2 go to 0 immediately. Assert rst coincident with an edge where w=1, wn=2, d=32'h55 -> reg 2 = 0 after release.

Source files
------------

// File: rtl/yreg_file_if.sv
// ---------------------------------------------------------------------------
// yreg_file_if
// Bus between the datapath and the two-read/one-write register file.
//   rn1, rn2 : read addresses (ADDR bits)
//   rd1, rd2 : read data (WIDTH bits). Combinational, with same-cycle
//              write-through.
//   wn       : write address (ADDR bits)
//   d        : write data (WIDTH bits)
//   w        : write enable, sampled on the rising clock edge
// The master modport is the datapath side. The slave modport is the
// register file.
// ---------------------------------------------------------------------------
interface yreg_file_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
);
  logic [ADDR-1:0]  rn1;
  logic [ADDR-1:0]  rn2;
  logic [ADDR-1:0]  wn;
  logic [WIDTH-1:0] d;
  logic             w;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  modport master (
    output rn1, rn2, wn, d, w,
    input  rd1, rd2
  );

  modport slave (
    input  rn1, rn2, wn, d, w,
    output rd1, rd2
  );
endinterface

// File: rtl/yreg_file.sv
// ---------------------------------------------------------------------------
// yreg_file
// Two-read, one-write flip-flop register file. It has 2**ADDR registers of
// WIDTH bits each. Register 0 is hardwired to zero.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset. It clears every register, and
//         while it is held both read ports return 0.
//   bus : yreg_file_if.slave (rn1/rn2/rd1/rd2 read ports, wn/d/w write port)
// Reads are combinational. A write targeting a read address in the same
// cycle is forwarded to that read port, so the operand muxes downstream see
// the value being written this cycle.
// ---------------------------------------------------------------------------
module yreg_file #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
) (
  input  logic       clk,
  input  logic       rst,
  yreg_file_if.slave bus
);

  localparam int N = 2 ** ADDR;

  // Heap-ordered mux trees. Node 1 is the root. The children of node k are
  // 2k and 2k+1. Leaves N..2N-1 hold registers 0..N-1, so walking from the
  // root with the address MSB first lands on leaf N+addr.
  logic [WIDTH-1:0] tree1 [1:2*N-1];
  logic [WIDTH-1:0] tree2 [1:2*N-1];

  // A write to address 0 is discarded. It neither stores nor bypasses.
  logic wrActive;
  logic hit1;
  logic hit2;

  assign wrActive = bus.w && (bus.wn != '0);
  assign hit1     = !rst && wrActive && (bus.wn == bus.rn1);
  assign hit2     = !rst && wrActive && (bus.wn == bus.rn2);

  genvar i, lv, j;

  for (i = 0; i < N; i++) begin : gReg
    logic [WIDTH-1:0] q;
    if (i == 0) begin : gZero
      assign q = '0;
    end else begin : gFf
      // The async clear overrides a write, even a write on the same edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (wrActive && (bus.wn == ADDR'(i))) begin
          q <= bus.d;
        end
      end
    end
    assign tree1[N+i] = q;
    assign tree2[N+i] = q;
  end

  for (lv = 0; lv < ADDR; lv++) begin : gLevel
    for (j = 0; j < (2 ** lv); j++) begin : gNode
      localparam int K = (2 ** lv) + j;
      assign tree1[K] = bus.rn1[ADDR-1-lv] ? tree1[2*K+1] : tree1[2*K];
      assign tree2[K] = bus.rn2[ADDR-1-lv] ? tree2[2*K+1] : tree2[2*K];
    end
  end

  // Leaf 0 is constant zero, so rnN == 0 already reads 0 through the tree.
  assign bus.rd1 = rst ? '0 : (hit1 ? bus.d : tree1[1]);
  assign bus.rd2 = rst ? '0 : (hit2 ? bus.d : tree2[1]);

endmodule

// File: tb/tb_yreg_file.sv
module tb_yreg_file;

  localparam int WIDTH = 32;
  localparam int ADDR  = 5;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  event chkEv;
  int   checks;
  int   failures;
  bit   stimDone;

  yreg_file_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  yreg_file #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on each strobe, pop queued expectations and compare them with
  // the DUT's read ports.
  initial begin
    forever begin
      @(chkEv);
      while (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checks++;
        if (bus.rd1 !== e.e1) begin
          failures++;
          $display("FAIL %s rd1: got %h expected %h", e.name, bus.rd1, e.e1);
        end
        checks++;
        if (bus.rd2 !== e.e2) begin
          failures++;
          $display("FAIL %s rd2: got %h expected %h", e.name, bus.rd2, e.e2);
        end
      end
    end
  end

  task automatic expect2(input string name, input logic [WIDTH-1:0] e1,
                         input logic [WIDTH-1:0] e2);
    exp_t e;
    #1;
    e.name = name;
    e.e1 = e1;
    e.e2 = e2;
    expQ.push_back(e);
    -> chkEv;
    #1;
  endtask

  task automatic setRead(input logic [ADDR-1:0] a1, input logic [ADDR-1:0] a2);
    bus.rn1 = a1;
    bus.rn2 = a2;
  endtask

  // Write one register across a single rising edge, then drop w.
  task automatic wr(input logic [ADDR-1:0] a, input logic [WIDTH-1:0] v);
    @(negedge clk);
    bus.w  = 1'b1;
    bus.wn = a;
    bus.d  = v;
    @(posedge clk);
    #1;
    bus.w = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    stimDone = 0;
    rst      = 1'b1;
    bus.w    = 1'b0;
    bus.wn   = '0;
    bus.d    = '0;
    setRead('0, '0);

    // 1. Reset: every address reads 0 on both ports.
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      setRead(ADDR'(a), ADDR'(31 - a));
      expect2("reset_read", 32'h0, 32'h0);
    end
    // Writes and bypass are ignored while rst is held.
    @(negedge clk);
    bus.w = 1'b1; bus.wn = 5'd5; bus.d = 32'h1234_5678;
    setRead(5'd5, 5'd5);
    expect2("reset_nobypass", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    bus.w = 1'b0;
    expect2("reset_nowrite", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expect2("after_release", 32'h0, 32'h0);

    // 2. Write then read.
    setRead('0, '0);
    wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    setRead(5'd5, 5'd5);
    expect2("write_read", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // 3. Register 0: no bypass, no store.
    @(negedge clk);
    bus.w = 1'b1; bus.wn = 5'd0; bus.d = 32'hFFFF_FFFF;
    setRead(5'd0, 5'd5);
    expect2("r0_nobypass", 32'h0, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    bus.w = 1'b0;
    @(negedge clk);
    setRead(5'd0, 5'd0);
    expect2("r0_nostore", 32'h0, 32'h0);

    // 4. Bypass on one port, then on both ports at once.
    wr(5'd7, 32'h11);
    wr(5'd3, 32'h33);
    @(negedge clk);
    setRead(5'd7, 5'd3);
    expect2("pre_bypass", 32'h11, 32'h33);
    bus.w = 1'b1; bus.wn = 5'd7; bus.d = 32'h22;
    expect2("bypass_p1", 32'h22, 32'h33);
    @(posedge clk);
    #1;
    bus.w = 1'b0;
    expect2("bypass_stored", 32'h22, 32'h33);
    @(negedge clk);
    setRead(5'd3, 5'd3);
    bus.w = 1'b1; bus.wn = 5'd3; bus.d = 32'h44;
    expect2("bypass_both", 32'h44, 32'h44);
    @(posedge clk);
    #1;
    bus.w = 1'b0;
    expect2("bypass_both_stored", 32'h44, 32'h44);

    // 5. Write disabled: no store and no bypass.
    @(negedge clk);
    bus.w = 1'b0; bus.wn = 5'd9; bus.d = 32'hABCD;
    setRead(5'd9, 5'd31);
    expect2("wdis_nobypass", 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    expect2("wdis_nostore", 32'h0, 32'h0);

    // 6. Reset asserted mid-operation.
    for (int r = 1; r <= 4; r++) wr(ADDR'(r), WIDTH'(r));
    @(negedge clk);
    setRead(5'd1, 5'd4);
    expect2("loaded_1_4", 32'h1, 32'h4);
    #1;
    rst = 1'b1;
    expect2("async_rst_now", 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    setRead(5'd2, 5'd3);
    expect2("async_rst_cleared", 32'h0, 32'h0);
    wr(5'd2, 32'h2);
    @(negedge clk);
    expect2("reg2_reloaded", 32'h2, 32'h0);
    bus.w = 1'b1; bus.wn = 5'd2; bus.d = 32'h55;
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.w = 1'b0;
    expect2("coincident_rst", 32'h0, 32'h0);
    wr(5'd2, 32'h55);
    @(negedge clk);
    expect2("write_after_rst", 32'h55, 32'h0);

    // Top address decodes to its own register; no aliasing with register 0.
    wr(5'd31, 32'hCAFE_F00D);
    @(negedge clk);
    setRead(5'd31, 5'd0);
    expect2("top_addr", 32'hCAFE_F00D, 32'h0);

    #5;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", expQ.size());
    end
    stimDone = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    if (!stimDone) begin
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
